// File: rtl/riscv_pkg.sv
// Shared encodings for the RV32I execute stage: ALU control, operand selects,
// forwarding selects and branch funct3 values, plus the branch-condition helper.
package riscv_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SRA  = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SRL  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam logic [1:0] SRCA_RS1  = 2'b00;
  localparam logic [1:0] SRCA_PC   = 2'b01;
  localparam logic [1:0] SRCA_ZERO = 2'b10;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  // The decoder has already chosen SUB or SLT/SLTU, so the condition only
  // needs "result is zero" and "result bit 0".
  function automatic logic branch_taken(input logic [2:0] funct3,
                                        input logic       res_zero,
                                        input logic       res_lsb);
    case (funct3)
      BR_BEQ:  branch_taken = res_zero;
      BR_BNE:  branch_taken = !res_zero;
      BR_BLT:  branch_taken = res_lsb;
      BR_BGE:  branch_taken = !res_lsb;
      BR_BLTU: branch_taken = res_lsb;
      BR_BGEU: branch_taken = !res_lsb;
      default: branch_taken = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rv_alu.sv
// Combinational RV32I ALU; undefined control codes produce zero.
module rv_alu
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic [3:0]      i_ctrl,
  output logic [XLEN-1:0] o_result
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] w_shamt;
  assign w_shamt = i_b[SHW-1:0];

  always_comb begin
    o_result = '0;
    case (i_ctrl)
      ALU_ADD:  o_result = i_a + i_b;
      ALU_SUB:  o_result = i_a - i_b;
      ALU_SLL:  o_result = i_a << w_shamt;
      ALU_SRA:  o_result = XLEN'($signed(i_a) >>> w_shamt);
      ALU_XOR:  o_result = i_a ^ i_b;
      ALU_SRL:  o_result = i_a >> w_shamt;
      ALU_SLT:  o_result = {{(XLEN-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      ALU_SLTU: o_result = {{(XLEN-1){1'b0}}, (i_a < i_b)};
      ALU_OR:   o_result = i_a | i_b;
      ALU_AND:  o_result = i_a & i_b;
      default:  o_result = '0;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// RV32I execute stage: forwarding, ALU, branch/jump resolution and the EX/MEM
// register. Handshake: a transfer happens on an edge where valid && ready are both high.
module ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [XLEN-1:0] in_imm,
  input  logic [3:0]      in_alu_ctrl,
  input  logic [1:0]      in_src_a,
  input  logic            in_src_b,
  input  logic            in_branch,
  input  logic            in_jal,
  input  logic            in_jalr,
  input  logic [2:0]      in_funct3,
  input  logic [4:0]      in_rd,
  input  logic            in_reg_write,
  input  logic            in_mem_read,
  input  logic            in_mem_write,
  input  logic [1:0]      fwd_a_sel,
  input  logic [1:0]      fwd_b_sel,
  input  logic [XLEN-1:0] fwd_mem_data,
  input  logic [XLEN-1:0] fwd_wb_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [XLEN-1:0] out_store_data,
  output logic [4:0]      out_rd,
  output logic            out_reg_write,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  logic [XLEN-1:0] w_fa, w_fb, w_a, w_b, w_alu;
  logic [XLEN-1:0] w_target_sum, w_link;
  logic            w_taken, w_jump_or_taken, w_accept;

  logic            r_valid;
  logic [XLEN-1:0] r_result, r_store_data;
  logic [4:0]      r_rd;
  logic            r_reg_write, r_mem_read, r_mem_write;

  always_comb begin
    w_fa = in_rs1_data;
    case (fwd_a_sel)
      FWD_MEM: w_fa = fwd_mem_data;
      FWD_WB:  w_fa = fwd_wb_data;
      default: w_fa = in_rs1_data;
    endcase
    w_fb = in_rs2_data;
    case (fwd_b_sel)
      FWD_MEM: w_fb = fwd_mem_data;
      FWD_WB:  w_fb = fwd_wb_data;
      default: w_fb = in_rs2_data;
    endcase
    w_a = '0;
    case (in_src_a)
      SRCA_RS1: w_a = w_fa;
      SRCA_PC:  w_a = in_pc;
      default:  w_a = '0;
    endcase
  end

  assign w_b = in_src_b ? in_imm : w_fb;

  rv_alu #(.XLEN(XLEN)) u_alu (
    .i_a      (w_a),
    .i_b      (w_b),
    .i_ctrl   (in_alu_ctrl),
    .o_result (w_alu)
  );

  // Target adder is separate from the ALU so branches can compare and add at once.
  assign w_target_sum    = (in_jalr ? w_fa : in_pc) + in_imm;
  assign w_link          = in_pc + XLEN'(4);
  assign w_taken         = branch_taken(in_funct3, (w_alu == '0), w_alu[0]);
  assign w_jump_or_taken = in_jal || in_jalr || (in_branch && w_taken);

  assign in_ready       = !r_valid || out_ready;
  assign w_accept       = in_valid && in_ready && !flush;
  assign redirect_valid = rst_n && w_accept && w_jump_or_taken;
  assign redirect_pc    = in_jalr ? {w_target_sum[XLEN-1:1], 1'b0} : w_target_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_result     <= '0;
      r_store_data <= '0;
      r_rd         <= '0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid      <= 1'b1;
      r_result     <= (in_jal || in_jalr) ? w_link : w_alu;
      r_store_data <= w_fb;
      r_rd         <= in_rd;
      r_reg_write  <= in_reg_write;
      r_mem_read   <= in_mem_read;
      r_mem_write  <= in_mem_write;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid      = r_valid;
  assign out_result     = r_result;
  assign out_store_data = r_store_data;
  assign out_rd         = r_rd;
  assign out_reg_write  = r_reg_write;
  assign out_mem_read   = r_mem_read;
  assign out_mem_write  = r_mem_write;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: inputs change 1 ns after a rising edge, combinational
// outputs are checked 1 ns later, registered outputs 1 ns after the following edge.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
  logic [3:0]  in_alu_ctrl;
  logic [1:0]  in_src_a;
  logic        in_src_b, in_branch, in_jal, in_jalr;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd;
  logic        in_reg_write, in_mem_read, in_mem_write;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [31:0] fwd_mem_data, fwd_wb_data;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] out_result, out_store_data;
  logic [4:0]  out_rd;
  logic        out_reg_write, out_mem_read, out_mem_write;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_alu_ctrl(in_alu_ctrl), .in_src_a(in_src_a), .in_src_b(in_src_b),
    .in_branch(in_branch), .in_jal(in_jal), .in_jalr(in_jalr), .in_funct3(in_funct3),
    .in_rd(in_rd), .in_reg_write(in_reg_write), .in_mem_read(in_mem_read),
    .in_mem_write(in_mem_write),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .fwd_mem_data(fwd_mem_data), .fwd_wb_data(fwd_wb_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_store_data(out_store_data), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    in_valid = 0; in_pc = 0; in_rs1_data = 0; in_rs2_data = 0; in_imm = 0;
    in_alu_ctrl = 0; in_src_a = 0; in_src_b = 0; in_branch = 0; in_jal = 0; in_jalr = 0;
    in_funct3 = 3'b010; in_rd = 0; in_reg_write = 0; in_mem_read = 0; in_mem_write = 0;
    fwd_a_sel = 0; fwd_b_sel = 0; fwd_mem_data = 0; fwd_wb_data = 0; flush = 0;
  endtask

  // Present an R-type style op on rs1/rs2.
  task automatic set_rr(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b);
    clear_in();
    in_valid = 1; in_alu_ctrl = ctrl; in_rs1_data = a; in_rs2_data = b;
    in_rd = 5'd3; in_reg_write = 1;
  endtask

  task automatic edge_then_settle();
    @(posedge clk); #1;
  endtask

  initial begin
    clear_in();
    out_ready = 1;
    rst_n = 0;
    #1;
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_out_result", out_result, 32'd0);
    chk("reset_redirect", {31'b0, redirect_valid}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    #1 chk("post_reset_in_ready", {31'b0, in_ready}, 32'd1);

    // ALU vectors, back to back
    set_rr(4'd1, 32'd5, 32'd7);
    edge_then_settle();
    chk("sub_valid", {31'b0, out_valid}, 32'd1);
    chk("sub_result", out_result, 32'hFFFF_FFFE);
    chk("sub_store_data", out_store_data, 32'd7);
    chk("sub_rd", {27'b0, out_rd}, 32'd3);
    set_rr(4'd3, 32'h8000_0000, 32'd4);
    edge_then_settle();
    chk("sra_result", out_result, 32'hF800_0000);
    set_rr(4'd7, 32'd1, 32'hFFFF_FFFF);
    edge_then_settle();
    chk("sltu_result", out_result, 32'd1);
    set_rr(4'd6, 32'd1, 32'hFFFF_FFFF);
    edge_then_settle();
    chk("slt_result", out_result, 32'd0);
    set_rr(4'd2, 32'h0000_0003, 32'd36);
    edge_then_settle();
    chk("sll_shamt_low5", out_result, 32'h0000_0030);
    set_rr(4'b1010, 32'd3, 32'd4);
    edge_then_settle();
    chk("undef_ctrl_result", out_result, 32'd0);

    // Branches: blt -1<1 taken; bge not taken; bgeu (unsigned 0xFFFFFFFF>=1) taken
    set_rr(4'd6, 32'hFFFF_FFFF, 32'd1);
    in_branch = 1; in_funct3 = 3'b100; in_pc = 32'h100; in_imm = 32'h20; in_reg_write = 0;
    #1;
    chk("blt_redirect_valid", {31'b0, redirect_valid}, 32'd1);
    chk("blt_redirect_pc", redirect_pc, 32'h120);
    in_funct3 = 3'b101;
    #1 chk("bge_not_taken", {31'b0, redirect_valid}, 32'd0);
    in_alu_ctrl = 4'd7; in_funct3 = 3'b111;
    #1 chk("bgeu_taken", {31'b0, redirect_valid}, 32'd1);
    in_alu_ctrl = 4'd1; in_funct3 = 3'b000; in_rs2_data = 32'hFFFF_FFFF;
    #1 chk("beq_taken", {31'b0, redirect_valid}, 32'd1);
    in_funct3 = 3'b010;
    #1 chk("funct3_010_never", {31'b0, redirect_valid}, 32'd0);
    edge_then_settle();

    // jalr
    clear_in();
    in_valid = 1; in_jalr = 1; in_rs1_data = 32'h1003; in_imm = 32'd4; in_pc = 32'h40;
    in_src_b = 1; in_rd = 5'd1; in_reg_write = 1;
    #1;
    chk("jalr_redirect_valid", {31'b0, redirect_valid}, 32'd1);
    chk("jalr_redirect_pc", redirect_pc, 32'h1006);
    edge_then_settle();
    chk("jalr_link", out_result, 32'h44);
    chk("jalr_rd", {27'b0, out_rd}, 32'd1);

    // Forwarding
    clear_in();
    in_valid = 1; in_rs1_data = 32'd99; in_rs2_data = 32'd77; in_imm = 32'd5; in_src_b = 1;
    fwd_a_sel = 2'b01; fwd_mem_data = 32'd10; fwd_b_sel = 2'b10; fwd_wb_data = 32'h0000_ABCD;
    in_mem_write = 1;
    edge_then_settle();
    chk("fwd_a_mem_result", out_result, 32'd15);
    chk("fwd_b_wb_store", out_store_data, 32'h0000_ABCD);
    chk("fwd_mem_write", {31'b0, out_mem_write}, 32'd1);

    // Stall: hold ADD 1+2 while a jal waits upstream
    set_rr(4'd0, 32'd1, 32'd2);
    edge_then_settle();
    chk("pre_stall_result", out_result, 32'd3);
    set_rr(4'd0, 32'd40, 32'd50);
    in_jal = 1; in_pc = 32'h200; in_imm = 32'h10;
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
      chk("stall_no_redirect", {31'b0, redirect_valid}, 32'd0);
      edge_then_settle();
      chk("stall_valid", {31'b0, out_valid}, 32'd1);
      chk("stall_result", out_result, 32'd3);
    end
    flush = 1;
    #1 chk("flush_no_redirect", {31'b0, redirect_valid}, 32'd0);
    edge_then_settle();
    chk("flush_valid", {31'b0, out_valid}, 32'd0);
    chk("flush_no_capture", out_result, 32'd3);

    // Back-to-back with drain: one result per cycle
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      set_rr(4'd0, 32'(i), 32'd100);
      edge_then_settle();
      chk("b2b_valid", {31'b0, out_valid}, 32'd1);
      chk("b2b_result", out_result, 32'(100 + i));
      #1 chk("b2b_in_ready", {31'b0, in_ready}, 32'd1);
    end
    clear_in();
    edge_then_settle();
    chk("drain_valid", {31'b0, out_valid}, 32'd0);
    chk("drain_hold_data", out_result, 32'd103);

    // Reset mid-stream
    set_rr(4'd0, 32'd7, 32'd8);
    edge_then_settle();
    chk("pre_reset_result", out_result, 32'd15);
    in_jal = 1;
    #2 rst_n = 0;
    #1;
    chk("midreset_valid", {31'b0, out_valid}, 32'd0);
    chk("midreset_result", out_result, 32'd0);
    chk("midreset_redirect", {31'b0, redirect_valid}, 32'd0);
    clear_in();
    edge_then_settle();
    rst_n = 1;
    #1 chk("after_midreset_in_ready", {31'b0, in_ready}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
